// File: rtl/macc_pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : macc_pass_sequencer
// Purpose  : Issues operand sets to a parallel MACC array over a multi-pass job
//            and accumulates each lane's results into one job output.
//            Optional macro MACC_SEQ_SATURATE_EN: saturating lane accumulation.
// Revision : 1.0
// ============================================================================
module macc_pass_sequencer #(
    parameter int NUM_MACC   = 5,
    parameter int MACC_WIDTH = 20,
    parameter int ACC_WIDTH  = 28,
    parameter int PASS_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_start,
    input  logic [PASS_WIDTH-1:0]          i_num_passes,
    output logic                           o_busy,
    input  logic                           i_src_valid,
    output logic                           o_src_ready,
    output logic                           o_macc_valid,
    input  logic                           i_macc_valid,
    input  logic [MACC_WIDTH*NUM_MACC-1:0] i_macc_data,
    output logic [ACC_WIDTH*NUM_MACC-1:0]  o_data,
    output logic                           o_valid,
    input  logic                           i_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } state_t;

    localparam logic [PASS_WIDTH:0] c_cnt_one = 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PASS_WIDTH-1:0] r_passes;
    logic [PASS_WIDTH-1:0] r_issued;
    logic [PASS_WIDTH-1:0] r_received;
    logic [PASS_WIDTH:0]   w_issued_inc;
    logic [PASS_WIDTH:0]   w_received_inc;
    logic                  w_start_ok;
    logic                  w_src_ready;
    logic                  w_xfer;
    logic                  w_rx;
    logic                  w_first;
    logic                  w_last_issue;
    logic                  w_last_rx;

    assign w_start_ok     = (r_state == S_IDLE) && i_start && (i_num_passes != '0);
    assign w_src_ready    = (r_state == S_ISSUE) && (r_issued < r_passes);
    assign w_xfer         = w_src_ready && i_src_valid;
    assign w_rx           = i_macc_valid && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
    assign w_first        = (r_received == '0);
    assign w_issued_inc   = {1'b0, r_issued} + c_cnt_one;
    assign w_received_inc = {1'b0, r_received} + c_cnt_one;
    assign w_last_issue   = (w_issued_inc == {1'b0, r_passes});
    assign w_last_rx      = (w_received_inc == {1'b0, r_passes});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A final result arriving while still in ISSUE goes straight to OUTPUT.
    always_comb begin
        w_state_nxt  = r_state;
        o_busy       = 1'b0;
        o_src_ready  = 1'b0;
        o_macc_valid = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                o_busy       = 1'b1;
                o_src_ready  = w_src_ready;
                o_macc_valid = w_xfer;
                if (w_rx && w_last_rx)
                    w_state_nxt = S_OUTPUT;
                else if (w_xfer && w_last_issue)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (w_rx && w_last_rx) w_state_nxt = S_OUTPUT;
            end
            S_OUTPUT: begin
                o_busy  = 1'b1;
                o_valid = 1'b1;
                if (i_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_passes   <= '0;
            r_issued   <= '0;
            r_received <= '0;
        end else if (w_start_ok) begin
            r_passes   <= i_num_passes;
            r_issued   <= '0;
            r_received <= '0;
        end else begin
            if (w_xfer) r_issued   <= w_issued_inc[PASS_WIDTH-1:0];
            if (w_rx)   r_received <= w_received_inc[PASS_WIDTH-1:0];
        end
    end

`ifdef MACC_SEQ_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

    for (genvar k = 0; k < NUM_MACC; k++) begin : g_lane
        logic signed [MACC_WIDTH-1:0] w_lane_in;
        logic signed [ACC_WIDTH-1:0]  w_lane_ext;
        logic signed [ACC_WIDTH-1:0]  w_acc_add;
        logic signed [ACC_WIDTH-1:0]  r_acc;

        assign w_lane_in  = i_macc_data[k*MACC_WIDTH +: MACC_WIDTH];
        assign w_lane_ext = ACC_WIDTH'(w_lane_in);

`ifdef MACC_SEQ_SATURATE_EN
        logic signed [ACC_WIDTH:0] w_sum;
        assign w_sum = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(w_lane_ext);
        // Overflow shows as the guard bit disagreeing with the result sign.
        always_comb begin
            w_acc_add = w_sum[ACC_WIDTH-1:0];
            if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1])
                w_acc_add = w_sum[ACC_WIDTH] ? c_acc_min : c_acc_max;
        end
`else
        assign w_acc_add = r_acc + w_lane_ext;
`endif

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else if (w_rx) begin
                r_acc <= w_first ? w_lane_ext : w_acc_add;
            end
        end

        assign o_data[k*ACC_WIDTH +: ACC_WIDTH] = r_acc;
    end

endmodule
`default_nettype wire

// File: tb/tb_macc_pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_macc_pass_sequencer
// Purpose  : Self-checking bench for macc_pass_sequencer (scoreboard queue).
// Revision : 1.0
// ============================================================================
module tb_macc_pass_sequencer;

    localparam int NM = 5;
    localparam int MW = 20;
    localparam int AW = 28;
    localparam int PW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [PW-1:0]     i_num_passes = '0;
    logic              o_busy;
    logic              i_src_valid = 1'b0;
    logic              o_src_ready;
    logic              o_macc_valid;
    logic              i_macc_valid = 1'b0;
    logic [MW*NM-1:0]  i_macc_data = '0;
    logic [AW*NM-1:0]  o_data;
    logic              o_valid;
    logic              i_ready = 1'b1;

    logic              wr_start = 1'b0;
    logic [PW-1:0]     wr_num = '0;
    logic              wr_busy;
    logic              wr_src_valid = 1'b0;
    logic              wr_src_ready;
    logic              wr_macc_valid_o;
    logic              wr_macc_valid_i = 1'b0;
    logic [MW-1:0]     wr_macc_data = '0;
    logic [MW-1:0]     wr_data;
    logic              wr_valid;
    logic              wr_ready = 1'b1;

    logic [AW*NM-1:0]  exp_q[$];
    logic [AW*NM-1:0]  last_exp = '0;
    int                n_checks = 0;
    int                n_fail = 0;

    macc_pass_sequencer #(
        .NUM_MACC(NM), .MACC_WIDTH(MW), .ACC_WIDTH(AW), .PASS_WIDTH(PW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_passes(i_num_passes),
        .o_busy(o_busy), .i_src_valid(i_src_valid), .o_src_ready(o_src_ready),
        .o_macc_valid(o_macc_valid), .i_macc_valid(i_macc_valid),
        .i_macc_data(i_macc_data), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready)
    );

    macc_pass_sequencer #(
        .NUM_MACC(1), .MACC_WIDTH(MW), .ACC_WIDTH(MW), .PASS_WIDTH(PW)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .i_start(wr_start), .i_num_passes(wr_num),
        .o_busy(wr_busy), .i_src_valid(wr_src_valid), .o_src_ready(wr_src_ready),
        .o_macc_valid(wr_macc_valid_o), .i_macc_valid(wr_macc_valid_i),
        .i_macc_data(wr_macc_data), .o_data(wr_data), .o_valid(wr_valid), .i_ready(wr_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        i_start      = 1'b1;
        i_num_passes = PW'(n);
        tick();
        i_start      = 1'b0;
        i_num_passes = '0;
    endtask

    task automatic wait_valid(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Zero-latency MACC: each issued pass returns its result in the same cycle.
    task automatic run_zl(input int n);
        int                sums[NM];
        logic signed [MW-1:0] t;
        logic [MW*NM-1:0]  d;
        logic [AW*NM-1:0]  e;
        for (int k = 0; k < NM; k++) sums[k] = 0;
        do_start(n);
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < NM; k++) begin
                t = MW'($urandom);
                d[k*MW +: MW] = t;
                sums[k] += int'(t);
            end
            i_src_valid  = 1'b1;
            i_macc_valid = 1'b1;
            i_macc_data  = d;
            tick();
        end
        i_src_valid  = 1'b0;
        i_macc_valid = 1'b0;
        for (int k = 0; k < NM; k++) e[k*AW +: AW] = AW'(sums[k]);
        exp_q.push_back(e);
    endtask

    function automatic int res3(input int p, input int k);
        if (p == 0) return k;
        if (p == 1) return -2 * k;
        return 5;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        i_src_valid = 1'b1;
        i_macc_valid = 1'b1;
        i_macc_data = '1;
        i_start = 1'b1;
        i_num_passes = 8'd3;
        repeat (3) tick();
        @(negedge clk);
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        n_checks++; if (o_src_ready !== 1'b0) begin n_fail++; $display("FAIL reset_src_ready got=%b exp=0", o_src_ready); end
        n_checks++; if (o_macc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_macc_valid got=%b exp=0", o_macc_valid); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        n_checks++; if (o_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", o_data); end
        tick();
        i_src_valid = 1'b0; i_macc_valid = 1'b0; i_macc_data = '0;
        i_start = 1'b0; i_num_passes = '0;
        rst_n = 1'b1;
        tick();
        last_exp = '0;
    endtask

    task automatic test_single_pass();
        logic [MW*NM-1:0] d = '0;
        logic [AW*NM-1:0] e = '0;
        logic [AW*NM-1:0] got_exp;
        d[0 +: MW] = MW'(100);
        e[0 +: AW] = AW'(100);
        exp_q.push_back(e);
        i_ready = 1'b1;
        do_start(1);
        i_src_valid = 1'b1;
        @(negedge clk);
        n_checks++; if (o_src_ready !== 1'b1) begin n_fail++; $display("FAIL sp_src_ready got=%b exp=1", o_src_ready); end
        n_checks++; if (o_macc_valid !== 1'b1) begin n_fail++; $display("FAIL sp_macc_valid got=%b exp=1", o_macc_valid); end
        tick();
        @(negedge clk);
        n_checks++; if (o_macc_valid !== 1'b0 || o_src_ready !== 1'b0) begin n_fail++; $display("FAIL sp_drain_no_issue got=%b/%b exp=0/0", o_macc_valid, o_src_ready); end
        tick();
        i_src_valid = 1'b0;
        i_macc_valid = 1'b1;
        i_macc_data = d;
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL sp_early_valid got=%b exp=0", o_valid); end
        tick();
        i_macc_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL sp_latency got=%b exp=1", o_valid); end
        got_exp = exp_q.pop_front();
        n_checks++; if (o_data !== got_exp) begin n_fail++; $display("FAIL sp_data got=%h exp=%h", o_data, got_exp); end
        last_exp = got_exp;
        tick();
        @(negedge clk);
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL sp_idle got=%b exp=0", o_busy); end
        tick();
    endtask

    task automatic test_three_pass();
        int src_s[8] = '{1, 0, 1, 0, 1, 1, 0, 0};
        int rx_s[8]  = '{-1, -1, 0, -1, -1, 1, 2, -1};
        int n_mv = 0;
        logic [MW*NM-1:0] d;
        logic [AW*NM-1:0] e;
        logic [AW*NM-1:0] got_exp;
        for (int k = 0; k < NM; k++) e[k*AW +: AW] = AW'(5 - k);
        exp_q.push_back(e);
        i_ready = 1'b1;
        do_start(3);
        for (int c = 0; c < 8; c++) begin
            i_src_valid  = (src_s[c] != 0);
            i_macc_valid = (rx_s[c] >= 0);
            d = '0;
            if (rx_s[c] >= 0)
                for (int k = 0; k < NM; k++) d[k*MW +: MW] = MW'(res3(rx_s[c], k));
            i_macc_data = d;
            @(negedge clk);
            if (o_macc_valid === 1'b1) n_mv++;
            if (c == 6) begin
                n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL tp_early_valid got=%b exp=0", o_valid); end
            end
            if (c == 7) begin
                n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL tp_valid got=%b exp=1", o_valid); end
                got_exp = exp_q.pop_front();
                n_checks++; if (o_data !== got_exp) begin n_fail++; $display("FAIL tp_data got=%h exp=%h", o_data, got_exp); end
                last_exp = got_exp;
            end
            tick();
        end
        i_src_valid = 1'b0; i_macc_valid = 1'b0; i_macc_data = '0;
        @(negedge clk);
        n_checks++; if (n_mv != 3) begin n_fail++; $display("FAIL tp_macc_count got=%0d exp=3", n_mv); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL tp_idle got=%b exp=0", o_busy); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [AW*NM-1:0] got_exp;
        int bad = 0;
        i_ready = 1'b0;
        run_zl(1);
        @(negedge clk);
        got_exp = exp_q.pop_front();
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_direct_output got=%b exp=1", o_valid); end
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (o_valid !== 1'b1 || o_data !== got_exp) bad++;
            tick();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_stable got=%0d_bad_cycles exp=0 data=%h exp_data=%h", bad, o_data, got_exp); end
        last_exp = got_exp;
        i_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_at_ready got=%b exp=1", o_valid); end
        tick();
        @(negedge clk);
        n_checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle got=%b/%b exp=0/0", o_busy, o_valid); end
        tick();
    endtask

    task automatic test_ignored_start();
        logic [MW*NM-1:0] d = '1;
        logic [AW*NM-1:0] e;
        logic [AW*NM-1:0] got_exp;
        bit found;
        i_ready = 1'b1;
        i_start = 1'b1; i_num_passes = '0;
        i_macc_valid = 1'b1; i_macc_data = d;
        tick();
        i_start = 1'b0; i_macc_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL ig_zero_start got=%b exp=0", o_busy); end
        n_checks++; if (o_data !== last_exp) begin n_fail++; $display("FAIL ig_idle_result got=%h exp=%h", o_data, last_exp); end
        tick();
        for (int k = 0; k < NM; k++) e[k*AW +: AW] = AW'(7 + k + 9);
        exp_q.push_back(e);
        do_start(2);
        i_start = 1'b1; i_num_passes = 8'd5; i_src_valid = 1'b1;
        tick();
        i_start = 1'b0; i_num_passes = '0;
        tick();
        i_src_valid = 1'b1;
        @(negedge clk);
        n_checks++; if (o_src_ready !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL ig_drain got=%b/%b exp=0/1", o_src_ready, o_busy); end
        tick();
        i_src_valid = 1'b0;
        for (int k = 0; k < NM; k++) d[k*MW +: MW] = MW'(7 + k);
        i_macc_valid = 1'b1; i_macc_data = d;
        tick();
        for (int k = 0; k < NM; k++) d[k*MW +: MW] = MW'(9);
        i_macc_data = d;
        tick();
        i_macc_valid = 1'b0;
        wait_valid(1, found);
        n_checks++; if (!found) begin n_fail++; $display("FAIL ig_valid got=0 exp=1"); end
        got_exp = exp_q.pop_front();
        n_checks++; if (o_data !== got_exp) begin n_fail++; $display("FAIL ig_data got=%h exp=%h", o_data, got_exp); end
        last_exp = got_exp;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [AW*NM-1:0] got_exp;
        bit found;
        i_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            run_zl(j == 0 ? 4 : 2);
            wait_valid(3, found);
            n_checks++; if (!found) begin n_fail++; $display("FAIL b2b_valid_%0d got=0 exp=1", j); end
            got_exp = exp_q.pop_front();
            n_checks++; if (o_data !== got_exp) begin n_fail++; $display("FAIL b2b_data_%0d got=%h exp=%h", j, o_data, got_exp); end
            last_exp = got_exp;
            tick();
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_queue got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        logic [MW-1:0] exp_w;
`ifdef MACC_SEQ_SATURATE_EN
        exp_w = 20'h7FFFF;
`else
        exp_w = 20'hFFFFE;
`endif
        wr_start = 1'b1; wr_num = 8'd2;
        tick();
        wr_start = 1'b0; wr_num = '0;
        wr_src_valid = 1'b1; wr_macc_valid_i = 1'b1; wr_macc_data = 20'h7FFFF;
        repeat (2) tick();
        wr_src_valid = 1'b0; wr_macc_valid_i = 1'b0; wr_macc_data = '0;
        @(negedge clk);
        n_checks++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got=%b exp=1", wr_valid); end
        n_checks++; if (wr_data !== exp_w) begin n_fail++; $display("FAIL wrap_data got=%h exp=%h", wr_data, exp_w); end
        tick();
    endtask

    task automatic test_reset_midjob();
        logic [MW*NM-1:0] d = '0;
        int seen = 0;
        i_ready = 1'b1;
        do_start(3);
        i_src_valid = 1'b1;
        repeat (3) tick();
        i_src_valid = 1'b0;
        for (int k = 0; k < NM; k++) d[k*MW +: MW] = MW'(11 * (k + 1));
        i_macc_valid = 1'b1; i_macc_data = d;
        tick();
        i_macc_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_src_ready !== 1'b0 || o_macc_valid !== 1'b0)
            begin n_fail++; $display("FAIL rm_ctrl got=%b%b%b%b exp=0000", o_busy, o_valid, o_src_ready, o_macc_valid); end
        n_checks++; if (o_data !== '0) begin n_fail++; $display("FAIL rm_data got=%h exp=0", o_data); end
        tick();
        i_macc_valid = 1'b1;
        repeat (2) tick();
        i_macc_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_data !== '0) seen++;
            tick();
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rm_late_result got=%0d_bad_cycles exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_three_pass();
        test_backpressure();
        test_ignored_start();
        test_back_to_back();
        test_wrap();
        test_reset_midjob();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/macc_pass_sequencer.md
MACC_PASS_SEQUENCER -- requirements
Module: macc_pass_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_MACC, default 5: number of parallel MACC lanes sequenced.
REQ-002 The block SHALL have parameter MACC_WIDTH, default 20: signed width of one lane result from the MACC array.
REQ-003 The block SHALL have parameter ACC_WIDTH, default 28: signed width of each lane accumulator; ACC_WIDTH >= MACC_WIDTH.
REQ-004 The block SHALL have parameter PASS_WIDTH, default 8: width of the pass-count field.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-007 The block SHALL have port i_start, input, 1: one-cycle job start request.
REQ-008 The block SHALL have port i_num_passes, input, PASS_WIDTH: passes (input-channel groups) per job, sampled with i_start.
REQ-009 The block SHALL have port o_busy, output, 1: high in any state other than IDLE.
REQ-010 The block SHALL have port i_src_valid, input, 1: upstream operand set (weights/activations) available.
REQ-011 The block SHALL have port o_src_ready, output, 1: sequencer accepts one operand set this cycle.
REQ-012 The block SHALL have port o_macc_valid, output, 1: i_valid strobe to the MACC array.
REQ-013 The block SHALL have port i_macc_valid, input, 1: o_valid returned by the MACC array.
REQ-014 The block SHALL have port i_macc_data, input, MACC_WIDTH*NUM_MACC: lane results, lane k at bits [(k+1)*MACC_WIDTH-1 : k*MACC_WIDTH].
REQ-015 The block SHALL have port o_data, output, ACC_WIDTH*NUM_MACC: accumulated job results, same lane packing.
REQ-016 The block SHALL have port o_valid, output, 1: o_data valid; held until accepted.
REQ-017 The block SHALL have port i_ready, input, 1: downstream accepts o_data.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, DRAIN, OUTPUT.
REQ-019 In IDLE, i_start=1 with i_num_passes>0 SHALL latch i_num_passes, clear issue/receive counters and go to ISSUE next cycle; i_start with i_num_passes=0 SHALL be ignored.
REQ-020 i_start outside IDLE SHALL be ignored without side effects.
REQ-021 In ISSUE, o_src_ready SHALL be 1 while issued count < latched passes; a transfer is i_src_valid & o_src_ready.
REQ-022 o_macc_valid SHALL equal the transfer condition combinationally (same cycle), so upstream operands are sampled by the MACC array that cycle; otherwise 0.
REQ-023 On the transfer that issues the last pass, the FSM SHALL go to DRAIN; o_src_ready SHALL be 0 in IDLE, DRAIN, OUTPUT.
REQ-024 Each i_macc_valid=1 in ISSUE or DRAIN SHALL increment the receive count; the first result of a job loads each lane accumulator with sign-extended i_macc_data, later results add sign-extended i_macc_data.
REQ-025 i_macc_valid in IDLE or OUTPUT SHALL be ignored (no accumulator or counter change).
REQ-026 Issue and receive in the same cycle SHALL both be honoured.
REQ-027 When the receive count reaches latched passes, the FSM SHALL enter OUTPUT next cycle with o_valid=1 and o_data = final accumulators; this applies even if the last result arrives while still in ISSUE (no DRAIN visit required).
REQ-028 In OUTPUT, o_data and o_valid SHALL hold stable until i_ready=1; o_valid&i_ready SHALL return the FSM to IDLE next cycle.
REQ-029 Default accumulation SHALL wrap modulo 2^ACC_WIDTH (two's complement).
REQ-030 Block latency from last MACC result to o_valid SHALL be exactly 1 cycle, independent of MACC pipeline depth.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, clear counters and accumulators; o_busy, o_src_ready, o_macc_valid, o_valid = 0, o_data = 0.
REQ-032 Reset mid-job SHALL abandon the job; MACC results arriving after reset release SHALL be ignored (IDLE).

Configuration
REQ-033 With macro MACC_SEQ_SATURATE_EN defined, each lane add SHALL saturate to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; undefined, accumulation SHALL wrap per REQ-029.

Verification
REQ-034 Single pass: start, passes=1, lane0 result 100 -> one o_macc_valid, o_valid one cycle after i_macc_valid, lane0 o_data=100.
REQ-035 Three passes, i_src_valid gapped, lane k results {k, -2k, 5} -> exactly 3 o_macc_valid, lane k o_data = 5-k.
REQ-036 Backpressure: i_ready=0 for 10 cycles in OUTPUT -> o_valid/o_data stable 10 cycles, IDLE one cycle after i_ready=1.
REQ-037 i_start during ISSUE and start with passes=0 in IDLE -> no state, counter or output change.
REQ-038 Reset asserted in DRAIN with results pending -> all outputs 0 next cycle, late i_macc_valid produces no o_valid.
REQ-039 ACC_WIDTH=20, two passes of 2^19-1 -> wraps to -2 without macro; 2^19-1 with MACC_SEQ_SATURATE_EN.
